disparity_median_filter: RTL and testbench
==========================================

Name: disparity_median_filter

Overview:
- 3x3 median post-filter on the disparity stream; removes isolated speckle from winner-take-all disparity selection.
- Sits directly downstream of the SGM disparity selection stage: consumes its pixel_disparity, de, h_sync and v_sync outputs.
- Drives the display/output formatter with the same stream format, delayed by a fixed latency.
- Line storage follows the project convention: every line is TOTAL_LINE_W clocks including blanking, and buffers advance every clock.

Parameters:
- TOTAL_LINE_W, 1650, total clocks per line including blanking; depth of each line delay.
- DATA_W, 8, disparity sample width.
- MED_STAGES, 3, register stages in the median network (fixed at 3; parameter exposed for latency math only).
- LATENCY, TOTAL_LINE_W + 1 + MED_STAGES, derived: input-to-output delay in clocks (localparam).

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- de_in  in  1  data enable from disparity stage.
- h_sync_in  in  1  horizontal sync.
- v_sync_in  in  1  vertical sync.
- pixel_in  in  DATA_W  disparity sample.
- bypass  in  1  1 = output unfiltered centre sample.
- de_out  out  1  delayed data enable.
- h_sync_out  out  1  delayed h_sync.
- v_sync_out  out  1  delayed v_sync.
- pixel_out  out  DATA_W  filtered disparity.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Let x(n) = {de_in, pixel_in} at cycle n, and W = TOTAL_LINE_W.
- Window at cycle n: samples x(n - k*W - j) for k, j in {0,1,2}. The centre is x(n - W - 1).
- Implementation: two W-deep line delays, each DATA_W+1 bits (de travels with data), plus a 3x3 register window.
- Syncs: h_sync and v_sync are delayed by exactly LATENCY via a shift/RAM delay.
  - de_out(n + LATENCY) = de_in(n).
  - Same rule for h_sync_out and v_sync_out.
- pixel_out at cycle m is the result for the window whose centre entered at m - LATENCY.
- Median rule:
  - If all 9 window de bits = 1 and bypass = 0: pixel_out = median of the 9 values, unsigned compare.
  - Otherwise: pixel_out = centre value unchanged. This covers border rows and columns, and windows straddling blanking.
- bypass is sampled together with the window at median-network entry and pipelined. Toggling it affects only windows entering on or after that cycle; no mixed or glitched outputs.
- Median network: pipelined compare-exchange network, 3 register stages, no stalls, one result per clock.
  - The output register is the last stage.
  - No arithmetic widening; ties resolve to either equal value (identical result).
- pixel_out is don't-care-free: it always holds the computed value, even when de_out = 0.
- Warm-up counter, width clog2(LATENCY+1):
  - Cleared by rst.
  - Increments each clock until it reaches LATENCY, then saturates.
  - While counter < LATENCY: de_out, h_sync_out, v_sync_out and pixel_out are forced to 0.
  - Line delay contents are not reset.
- Reset values: de_out = 0, h_sync_out = 0, v_sync_out = 0, pixel_out = 0, counter = 0, median pipeline registers = 0.
- Reset mid-frame: outputs go to 0 on the clock after rst is sampled high. They stay 0 for LATENCY clocks after rst deasserts, then resume with whatever the delays hold.
- No backpressure; the input is a continuous video timing stream.

Test Plan:
- TOTAL_LINE_W=16, 10-pixel active lines, 6 active rows, all pixels = 7:
  - Interior outputs = 7.
  - de_out/h_sync_out/v_sync_out equal the inputs shifted by exactly 20 clocks.
- Same frame with value 5 and a single pixel of 31 at row 2, col 4 (interior): output at that position = 5; no 31 appears anywhere in the output.
- Ramp frame, pixel = col index:
  - Interior outputs equal col (median preserves the ramp).
  - Row 0, last row, col 0 and col 9 output the raw input unchanged.
- bypass=1 throughout the impulse frame: output at row 2, col 4 = 31.
  - Toggle bypass mid-row: outputs switch exactly at the pixel whose window entered on the toggle cycle.
- Assert rst for 2 cycles mid-frame:
  - All outputs = 0 from the next clock through 20 clocks after deassertion.
  - Sync outputs then match inputs delayed by 20.
- Random 8-bit frames, 3 consecutive frames, checked against a reference model of the median/border rule: zero mismatches, including across the v_sync boundaries.

Source files
------------

// File: rtl/disparity_median_filter_if.sv
// Video-timing stream bundle for the disparity median post-filter.
// master: upstream/driver side; slave: the filter itself.
interface disparity_median_filter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              de_in;
  logic              h_sync_in;
  logic              v_sync_in;
  logic [DATA_W-1:0] pixel_in;
  logic              bypass;
  logic              de_out;
  logic              h_sync_out;
  logic              v_sync_out;
  logic [DATA_W-1:0] pixel_out;

  modport master (
    output de_in, h_sync_in, v_sync_in, pixel_in, bypass,
    input  de_out, h_sync_out, v_sync_out, pixel_out
  );

  modport slave (
    input  de_in, h_sync_in, v_sync_in, pixel_in, bypass,
    output de_out, h_sync_out, v_sync_out, pixel_out
  );
endinterface

// File: rtl/disparity_median_filter.sv
// 3x3 median post-filter on the disparity stream. Two full-line delays
// (de travels with the sample) feed a 3x3 window; a 3-stage compare-exchange
// network produces the median, or the raw centre at borders/blanking/bypass.
module disparity_median_filter #(
  parameter int unsigned TOTAL_LINE_W = 1650,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MED_STAGES   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  disparity_median_filter_if.slave vid
);
  localparam int unsigned LATENCY    = TOTAL_LINE_W + 1 + MED_STAGES;
  localparam int unsigned CNT_W      = $clog2(LATENCY + 1);
  localparam int unsigned SW         = DATA_W + 1;
  localparam int unsigned LB_W       = TOTAL_LINE_W * SW;
  localparam int unsigned SYNC_DEPTH = LATENCY - 1;
  localparam int unsigned SD_W       = SYNC_DEPTH * 3;

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Delay state: advances every clock and is never reset.
  logic [LB_W-1:0]           lb1_q, lb1_d, lb2_q, lb2_d;
  logic [2:0][1:0][SW-1:0]   win_q, win_d;
  logic [SD_W-1:0]           sd_q, sd_d;

  // Median pipeline and output state.
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0][DATA_W-1:0]    s1_lo_q, s1_lo_d, s1_mid_q, s1_mid_d, s1_hi_q, s1_hi_d;
  pix_t                      s1_ctr_q, s1_ctr_d;
  logic                      s1_sel_q, s1_sel_d;
  pix_t                      s2_a_q, s2_a_d, s2_b_q, s2_b_d, s2_c_q, s2_c_d, s2_ctr_q, s2_ctr_d;
  logic                      s2_sel_q, s2_sel_d;
  pix_t                      pixel_out_q, pixel_out_d;
  logic                      de_out_q, de_out_d, h_sync_out_q, h_sync_out_d;
  logic                      v_sync_out_q, v_sync_out_d;

  logic [2:0][2:0][SW-1:0]   tap;
  logic [2:0]                sync_tail;
  logic                      warm;
  logic                      all_de;

  // Line delays, window shift and sync delay next-state.
  always_comb begin
    tap[0][0] = {vid.de_in, vid.pixel_in};
    tap[1][0] = lb1_q[LB_W-1 -: SW];
    tap[2][0] = lb2_q[LB_W-1 -: SW];
    tap[0][1] = win_q[0][0];
    tap[0][2] = win_q[0][1];
    tap[1][1] = win_q[1][0];
    tap[1][2] = win_q[1][1];
    tap[2][1] = win_q[2][0];
    tap[2][2] = win_q[2][1];
    lb1_d = {lb1_q[LB_W-SW-1:0], tap[0][0]};
    lb2_d = {lb2_q[LB_W-SW-1:0], tap[1][0]};
    win_d[0] = {win_q[0][0], tap[0][0]};
    win_d[1] = {win_q[1][0], tap[1][0]};
    win_d[2] = {win_q[2][0], tap[2][0]};
    sd_d = {sd_q[SD_W-4:0], vid.de_in, vid.h_sync_in, vid.v_sync_in};
    sync_tail = sd_q[SD_W-1 -: 3];
  end

  // Median network: row sort, then max-of-lows / med-of-mids / min-of-highs, then final med3.
  always_comb begin
    warm   = (cnt_q >= CNT_W'(LATENCY));
    cnt_d  = warm ? cnt_q : cnt_q + 1'b1;
    all_de = tap[0][0][DATA_W] & tap[0][1][DATA_W] & tap[0][2][DATA_W] &
             tap[1][0][DATA_W] & tap[1][1][DATA_W] & tap[1][2][DATA_W] &
             tap[2][0][DATA_W] & tap[2][1][DATA_W] & tap[2][2][DATA_W];
    s1_lo_d  = '0;
    s1_mid_d = '0;
    s1_hi_d  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      s1_lo_d[k]  = min2(min2(tap[k][0][DATA_W-1:0], tap[k][1][DATA_W-1:0]), tap[k][2][DATA_W-1:0]);
      s1_mid_d[k] = med3(tap[k][0][DATA_W-1:0], tap[k][1][DATA_W-1:0], tap[k][2][DATA_W-1:0]);
      s1_hi_d[k]  = max2(max2(tap[k][0][DATA_W-1:0], tap[k][1][DATA_W-1:0]), tap[k][2][DATA_W-1:0]);
    end
    s1_ctr_d = tap[1][1][DATA_W-1:0];
    s1_sel_d = all_de & ~vid.bypass;
    s2_a_d   = max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
    s2_b_d   = med3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
    s2_c_d   = min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
    s2_ctr_d = s1_ctr_q;
    s2_sel_d = s1_sel_q;
    pixel_out_d  = '0;
    de_out_d     = 1'b0;
    h_sync_out_d = 1'b0;
    v_sync_out_d = 1'b0;
    if (warm) begin
      pixel_out_d  = s2_sel_q ? med3(s2_a_q, s2_b_q, s2_c_q) : s2_ctr_q;
      de_out_d     = sync_tail[2];
      h_sync_out_d = sync_tail[1];
      v_sync_out_d = sync_tail[0];
    end
  end

  // Delay storage registers (contents survive reset).
  always_ff @(posedge clk) begin
    lb1_q <= lb1_d;
    lb2_q <= lb2_d;
    win_q <= win_d;
    sd_q  <= sd_d;
  end

  // Warm-up counter, median pipeline and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      s1_lo_q      <= '0;
      s1_mid_q     <= '0;
      s1_hi_q      <= '0;
      s1_ctr_q     <= '0;
      s1_sel_q     <= 1'b0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      s2_c_q       <= '0;
      s2_ctr_q     <= '0;
      s2_sel_q     <= 1'b0;
      pixel_out_q  <= '0;
      de_out_q     <= 1'b0;
      h_sync_out_q <= 1'b0;
      v_sync_out_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_lo_q      <= s1_lo_d;
      s1_mid_q     <= s1_mid_d;
      s1_hi_q      <= s1_hi_d;
      s1_ctr_q     <= s1_ctr_d;
      s1_sel_q     <= s1_sel_d;
      s2_a_q       <= s2_a_d;
      s2_b_q       <= s2_b_d;
      s2_c_q       <= s2_c_d;
      s2_ctr_q     <= s2_ctr_d;
      s2_sel_q     <= s2_sel_d;
      pixel_out_q  <= pixel_out_d;
      de_out_q     <= de_out_d;
      h_sync_out_q <= h_sync_out_d;
      v_sync_out_q <= v_sync_out_d;
    end
  end

  assign vid.pixel_out  = pixel_out_q;
  assign vid.de_out     = de_out_q;
  assign vid.h_sync_out = h_sync_out_q;
  assign vid.v_sync_out = v_sync_out_q;
endmodule

// File: tb/tb_disparity_median_filter.sv
// Bench for disparity_median_filter: short lines (16 clocks), 10 active
// pixels, 6 active rows, 8 lines per frame; reference model of the
// median/border rule with a warm-up/reset gate model.
module tb_disparity_median_filter;
  localparam int W     = 16;
  localparam int DW    = 8;
  localparam int LAT   = W + 1 + 3;
  localparam int ACT   = 10;
  localparam int ROWS  = 6;
  localparam int LINES = 8;

  typedef struct packed { logic de; logic h; logic v; } sync_t;
  typedef struct { bit chk; logic [7:0] pix; bit dchk; logic [7:0] dval; } pix_e_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disparity_median_filter_if #(.DATA_W(DW)) vid ();

  disparity_median_filter #(
    .TOTAL_LINE_W(W),
    .DATA_W      (DW),
    .MED_STAGES  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vid)
  );

  always #5 clk = ~clk;

  logic [8:0] hist [$];
  sync_t      sq [$];
  pix_e_t     pq [$];
  int         iter       = 0;
  int         bcnt       = 0;
  bit         gated_prev = 1'b1;
  int         checks     = 0;
  int         errors     = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s iter=%0d observed=%0d expected=%0d", tag, iter, obs, exp);
    end
  endtask

  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = v;
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (a[j] < a[j-1]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    return a[4];
  endfunction

  // One clock: check what the DUT shows now, then drive the next input and
  // push the expectations it implies.
  task automatic step(input bit r, input bit de, input bit h, input bit v,
                      input logic [7:0] p, input bit byp,
                      input bit dchk, input logic [7:0] dval);
    sync_t      se;
    pix_e_t     pe;
    logic [8:0] s;
    logic [7:0] win [9];
    bit         all_de;
    int         idx;
    @(negedge clk);
    if (iter > 0) begin
      se = '0;
      pe = '{chk: 1'b0, pix: '0, dchk: 1'b0, dval: '0};
      if (iter >= LAT) se = sq.pop_front();
      if (iter >= 3) pe = pq.pop_front();
      if (gated_prev) begin
        check("de_gated",    {7'b0, vid.de_out},     8'd0);
        check("hsync_gated", {7'b0, vid.h_sync_out}, 8'd0);
        check("vsync_gated", {7'b0, vid.v_sync_out}, 8'd0);
        check("pixel_gated", vid.pixel_out,          8'd0);
      end else begin
        check("de_out",     {7'b0, vid.de_out},     {7'b0, se.de});
        check("h_sync_out", {7'b0, vid.h_sync_out}, {7'b0, se.h});
        check("v_sync_out", {7'b0, vid.v_sync_out}, {7'b0, se.v});
        if (pe.chk)  check("pixel_out",      vid.pixel_out, pe.pix);
        if (pe.dchk) check("pixel_directed", vid.pixel_out, pe.dval);
      end
    end
    rst           = r;
    vid.de_in     = de;
    vid.h_sync_in = h;
    vid.v_sync_in = v;
    vid.pixel_in  = p;
    vid.bypass    = byp;
    hist.push_back({de, p});
    sq.push_back({de, h, v});
    pe.chk = 1'b1;
    pe.pix = '0;
    all_de = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        idx = iter - k * W - j;
        if (idx < 0) begin
          pe.chk = 1'b0;
          win[k*3+j] = '0;
        end else begin
          s = hist[idx];
          win[k*3+j] = s[7:0];
          all_de = all_de & s[8];
        end
      end
    end
    if (pe.chk) pe.pix = (all_de && !byp) ? med9(win) : win[4];
    pe.dchk = dchk;
    pe.dval = dval;
    pq.push_back(pe);
    gated_prev = r || (bcnt < LAT);
    bcnt = r ? 0 : ((bcnt < LAT) ? bcnt + 1 : bcnt);
    iter++;
  endtask

  // kind: 0 const 7, 1 impulse (5 with 31 at row2 col4), 2 ramp, 3 random, 4 blank
  // bmode: 0 off, 1 on, 2 switches on at row3 col5 (window centred on row2 col4)
  task automatic run_frame(input int kind, input int bmode, input int rst_at);
    bit         act, byp, r, dchk;
    logic [7:0] p, dval;
    int         cyc;
    for (int line = 0; line < LINES; line++) begin
      for (int col = 0; col < W; col++) begin
        cyc  = line * W + col;
        act  = (kind != 4) && (line < ROWS) && (col < ACT);
        r    = (rst_at >= 0) && (cyc >= rst_at) && (cyc < rst_at + 2);
        byp  = (bmode == 1) || (bmode == 2 && (line > 3 || (line == 3 && col >= 5)));
        case (kind)
          0:       p = 8'd7;
          1:       p = (line == 2 && col == 4) ? 8'd31 : 8'd5;
          2:       p = 8'(col);
          3:       p = 8'($urandom_range(0, 255));
          default: p = 8'd0;
        endcase
        if (!act && kind != 3) p = 8'd0;
        dchk = 1'b0;
        dval = '0;
        if (kind == 0 && line == 3 && col == 5) begin dchk = 1'b1; dval = 8'd7; end
        if (kind == 1 && line == 3 && col == 5) begin dchk = 1'b1; dval = (bmode == 0) ? 8'd5 : 8'd31; end
        if (kind == 1 && line == 3 && col == 4) begin dchk = 1'b1; dval = 8'd5; end
        if (kind == 2 && line == 1 && col == 1)  begin dchk = 1'b1; dval = 8'd0; end
        if (kind == 2 && line == 1 && col == 10) begin dchk = 1'b1; dval = 8'd9; end
        if (kind == 2 && line == 4 && col == 6)  begin dchk = 1'b1; dval = 8'd5; end
        step(r, act, (col >= 12 && col < 14), (line == ROWS), p, byp, dchk, dval);
      end
    end
  endtask

  initial begin
    vid.de_in     = 1'b0;
    vid.h_sync_in = 1'b0;
    vid.v_sync_in = 1'b0;
    vid.pixel_in  = '0;
    vid.bypass    = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    run_frame(0, 0, -1);
    run_frame(1, 0, -1);
    run_frame(2, 0, -1);
    run_frame(1, 1, -1);
    run_frame(1, 2, -1);
    run_frame(0, 0, 3 * W + 5);
    run_frame(3, 0, -1);
    run_frame(3, 0, -1);
    run_frame(3, 0, -1);
    run_frame(4, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
